i2c_target_responder: RTL and testbench
=======================================

Name: i2c_target_responder

Overview:
- I2C target (slave) responder that sits on the shared open-drain SCL/SDA bus alongside the multi-master I2C_top.
- Watches for START/STOP conditions and matches its 7-bit address.
- Write transfers: acknowledges the address and each byte, and hands received bytes to local logic.
- Read transfers: requests bytes from local logic and shifts them out, honouring the master's ACK/NACK.

Parameters:
- TARGET_ADDR, 7'h47, 7-bit bus address this target responds to.
- SYNC_STAGES, 2, synchroniser depth on scl_i/sda_i (legal range 2..3).

Ports:
- clk  in  1  system clock (50 MHz nominal); must be at least 8x the SCL frequency.
- rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  SCL as seen on the bus.
- sda_i  in  1  SDA as seen on the bus.
- sda_oe  out  1  1 = pull SDA low; 0 = release. SCL is never driven.
- rx_data  out  8  last byte written by the master; valid while rx_valid=1.
- rx_valid  out  1  single-cycle pulse per received data byte.
- tx_data  in  8  byte to return on a read; sampled one cycle after tx_req.
- tx_req  out  1  single-cycle pulse requesting the next read byte.
- addressed  out  1  high from address ACK until STOP, repeated START or NACK.
- rd_nwr  out  1  R/W bit of the current transfer (1 = read).

Behaviour:
- Reset: all outputs 0, synchronisers preset to 1, state IDLE.
- Reset is async assert and releases on a clk edge.
- Reset mid-transfer releases SDA immediately.
- Synchronise scl_i/sda_i through SYNC_STAGES flops, then register once more for edge detection. Bus events lag the pins by SYNC_STAGES+1 cycles.
- START: SDA falls while SCL=1. STOP: SDA rises while SCL=1.
- Both conditions are detected in every state and override it:
  - START (including repeated START): release SDA, clear bit counter, go to ADDR.
  - STOP: release SDA, go to IDLE.
- Bit counter is 3 bits, MSB first.
- Data is sampled on the SCL rising edge; sda_oe changes only on the cycle after an SCL falling edge is detected.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - On the 8th rising edge, compare bits[7:1] with TARGET_ADDR.
    - On match: latch rd_nwr = bit0. If read, pulse tx_req on this cycle. Go to ADDR_ACK.
    - On mismatch: go to WAIT_STOP.
  - ADDR_ACK: on the next falling edge assert sda_oe and set addressed=1.
    - Write: on the following falling edge release SDA, go to WR_DATA.
    - Read: on the following falling edge load the latched tx_data, drive its bit7 (sda_oe = ~bit), go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - On the 8th rising edge, update rx_data and pulse rx_valid for one cycle.
    - The next falling edge asserts sda_oe (ACK). Go to WR_ACK.
  - WR_ACK: on the next falling edge release SDA, go to WR_DATA.
  - RD_DATA: drive the remaining bits on successive falling edges. The falling edge after bit0 releases SDA. Go to RD_ACK.
  - RD_ACK: sample SDA on the rising edge.
    - 0 (ACK): pulse tx_req. The next falling edge loads tx_data, drives bit7, and goes to RD_DATA.
    - 1 (NACK): clear addressed, go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- tx_data is captured exactly one clk cycle after tx_req. The local side must present it combinationally or from a register updated that cycle.
- The target never ACKs a mismatched address. The master sees NACK through the bus pull-up.
- SDA glitches while SCL=0 are ignored. A START/STOP during a byte aborts that byte, and rx_valid does not fire for it.

Optional Feature:
- I2C_TARGET_GCALL_EN
  - Defined: address byte 8'h00 (general call, write) is also ACKed, with rd_nwr=0 and subsequent bytes delivered on rx_data/rx_valid. Address 8'h01 (general call with R/W=1, read) is NACKed.
  - Undefined: only TARGET_ADDR matches; 8'h00 goes to WAIT_STOP.

Test Plan:
- Master writes address 8'h8E then data 8'hA5, 8'hC3, then STOP -> three ACKs observed, rx_valid pulses twice with rx_data A5 then C3, addressed returns to 0 after STOP.
- Master sends address 8'hFE -> SDA stays high in the ACK slot, sda_oe never asserted, no rx_valid or tx_req until the next START.
- Master reads with address 8'h8F, tx_data 8'h3C then 8'h96, master ACKs byte 1 and NACKs byte 2 -> bus carries 3C, 96; tx_req pulses twice; SDA released after the NACK; state WAIT_STOP.
- Write 8'h8E, byte 8'h11, repeated START, then 8'h8F read -> rx_data 11, then rd_nwr=1 and tx_req pulse with no intervening STOP.
- Assert rst while driving bit 5 of a read byte -> sda_oe=0 within the same cycle, all outputs 0, next START is decoded normally.
- With I2C_TARGET_GCALL_EN: address 8'h00 then byte 8'h06 -> ACK, rx_valid with 06. Without it: NACK.

Source files
------------

// File: rtl/i2c_target_responder.sv
// I2C target responder: START/STOP detection, 7-bit address match, write/read byte handling.
// Optional general-call acceptance (address byte 8'h00) when I2C_TARGET_GCALL_EN is defined.
module i2c_target_responder #(
  parameter logic [6:0]  TARGET_ADDR = 7'h47,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       rd_nwr
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_d1_q, sda_d1_q;
  logic                   scl_c, sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [7:0]             byte_c;
  logic                   match_c, gcall_c;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q;
  logic       tx_cap_q;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       addressed_q, addressed_d;
  logic       rd_nwr_q, rd_nwr_d;

  // Bus-level event decode from the synchronised pins and their one-cycle-old copy
  assign scl_c      = scl_sync_q[SYNC_STAGES-1];
  assign sda_c      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_c = scl_c & ~scl_d1_q;
  assign scl_fall_c = ~scl_c & scl_d1_q;
  assign start_c    = scl_c & scl_d1_q & sda_d1_q & ~sda_c;
  assign stop_c     = scl_c & scl_d1_q & ~sda_d1_q & sda_c;
  assign byte_c     = {rx_shift_q, sda_c};

`ifdef I2C_TARGET_GCALL_EN
  assign gcall_c = (byte_c == 8'h00);
`else
  assign gcall_c = 1'b0;
`endif
  assign match_c = (byte_c[7:1] == TARGET_ADDR) || gcall_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    addressed_d = addressed_q;
    rd_nwr_d    = rd_nwr_q;

    if (start_c) begin
      sda_oe_d    = 1'b0;
      cnt_d       = 3'd0;
      addressed_d = 1'b0;
      state_d     = ADDR;
    end else if (stop_c) begin
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise_c) begin
            rx_shift_d = byte_c[6:0];
            cnt_d      = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'd7) begin
              if (match_c) begin
                rd_nwr_d = sda_c;
                tx_req_d = sda_c;
                state_d  = ADDR_ACK;
              end else begin
                state_d  = WAIT_STOP;
              end
            end
          end
        end
        // sda_oe_q doubles as the phase flag: first fall drives ACK, second ends the slot
        ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!sda_oe_q) begin
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
            end else if (rd_nwr_q) begin
              tx_shift_d = tx_hold_q[6:0];
              sda_oe_d   = ~tx_hold_q[7];
              cnt_d      = 3'd0;
              state_d    = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise_c) begin
            rx_shift_d = byte_c[6:0];
            cnt_d      = 3'(cnt_q + 3'd1);
            if (cnt_q == 3'd7) begin
              rx_data_d  = byte_c;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall_c) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall_c) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              cnt_d      = 3'(cnt_q + 3'd1);
            end
          end
        end
        // cnt_q == 0 marks "master ACKed, next byte requested"
        RD_ACK: begin
          if (scl_rise_c) begin
            if (!sda_c) begin
              tx_req_d = 1'b1;
              cnt_d    = 3'd0;
            end else begin
              addressed_d = 1'b0;
              state_d     = WAIT_STOP;
            end
          end else if (scl_fall_c && cnt_q == 3'd0) begin
            tx_shift_d = tx_hold_q[6:0];
            sda_oe_d   = ~tx_hold_q[7];
            state_d    = RD_DATA;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_d1_q    <= 1'b1;
      sda_d1_q    <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 7'd0;
      tx_hold_q   <= 8'd0;
      tx_cap_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      addressed_q <= 1'b0;
      rd_nwr_q    <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_d1_q    <= scl_c;
      sda_d1_q    <= sda_c;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      // Local side presents tx_data during the cycle after tx_req
      tx_cap_q    <= tx_req_q;
      if (tx_cap_q) tx_hold_q <= tx_data;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      addressed_q <= addressed_d;
      rd_nwr_q    <= rd_nwr_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign addressed = addressed_q;
  assign rd_nwr    = rd_nwr_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Scoreboard bench for i2c_target_responder: a bit-banged master issues transfers,
// expected rx bytes / tx requests / bus observations are queued and checked by monitors.
module tb_i2c_target_responder;

  localparam int Q = 8;

  logic       clk, rst;
  logic       scl_i, sda_i;
  logic       sda_oe, rx_valid, tx_req, addressed, rd_nwr;
  logic [7:0] rx_data, tx_data;
  logic       m_scl_low, m_sda_low;

  int checks = 0;
  int passes = 0;
  int oe_cycles = 0;
  int oe_mark;

  int         exp_rx[$];
  int         exp_req[$];
  int         exp_bus[$];
  int         obs_bus[$];
  logic [7:0] tx_q[$];

  assign scl_i = ~m_scl_low;
  assign sda_i = ~(m_sda_low | sda_oe);

  i2c_target_responder #(.TARGET_ADDR(7'h47), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .addressed(addressed), .rd_nwr(rd_nwr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitors: compare every DUT presentation against the scoreboard queues
  always @(negedge clk) begin
    if (!rst && sda_oe) oe_cycles <= oe_cycles + 1;
    if (!rst && rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++;
        $display("FAIL rx_valid_unexpected: got data %02h, expected no pulse", rx_data);
      end else chk("rx_data", int'(rx_data), exp_rx.pop_front());
    end
    if (!rst && tx_req) begin
      if (exp_req.size() == 0) begin
        checks++;
        $display("FAIL tx_req_unexpected: got pulse, expected none");
      end else chk("tx_req_rd_nwr", int'(rd_nwr), exp_req.pop_front());
    end
    if (obs_bus.size() > 0) begin
      if (exp_bus.size() == 0) begin
        checks++;
        $display("FAIL bus_unexpected: got %0h, expected nothing", obs_bus.pop_front());
      end else chk("bus", obs_bus.pop_front(), exp_bus.pop_front());
    end
  end

  // Local read-data source: next byte presented in the cycle after tx_req
  initial begin
    tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_req) tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_cond();
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    m_sda_low = ~b;   wait_q();
    m_scl_low = 1'b0; wait_q();
    seen = sda_i;     wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    obs_bus.push_back(int'(s));
  endtask

  task automatic read_byte(input logic nack);
    logic s;
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      v = {v[6:0], s};
    end
    clock_bit(nack, s);
    obs_bus.push_back(int'(v));
  endtask

  function automatic int outs();
    return int'({sda_oe, rx_data, rx_valid, tx_req, addressed, rd_nwr});
  endfunction

  initial begin
    logic s;
    rst = 1'b1; m_scl_low = 1'b0; m_sda_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    wait_q();
    chk("post_reset_outputs", outs(), 0);

    // Write 8E, A5, C3, STOP
    exp_bus.push_back(0); exp_bus.push_back(0); exp_bus.push_back(0);
    exp_rx.push_back(8'hA5); exp_rx.push_back(8'hC3);
    start_cond();
    write_byte(8'h8E);
    chk("wr_addressed", int'(addressed), 1);
    chk("wr_rd_nwr", int'(rd_nwr), 0);
    write_byte(8'hA5);
    write_byte(8'hC3);
    stop_cond();
    chk("wr_addressed_after_stop", int'(addressed), 0);
    wait_q();

    // Mismatched address FE: no ACK anywhere, SDA never pulled
    oe_mark = oe_cycles;
    exp_bus.push_back(1); exp_bus.push_back(1);
    start_cond();
    write_byte(8'hFE);
    write_byte(8'h00);
    stop_cond();
    chk("mismatch_oe_cycles", oe_cycles - oe_mark, 0);
    wait_q();

    // Read 8F: 3C (ACK), 96 (NACK)
    tx_q.push_back(8'h3C); tx_q.push_back(8'h96);
    exp_req.push_back(1); exp_req.push_back(1);
    exp_bus.push_back(0); exp_bus.push_back(8'h3C); exp_bus.push_back(8'h96);
    start_cond();
    write_byte(8'h8F);
    read_byte(1'b0);
    read_byte(1'b1);
    chk("rd_nack_sda_oe", int'(sda_oe), 0);
    chk("rd_nack_addressed", int'(addressed), 0);
    stop_cond();
    wait_q();

    // Write 11, repeated START, read one byte
    exp_bus.push_back(0); exp_bus.push_back(0);
    exp_rx.push_back(8'h11);
    start_cond();
    write_byte(8'h8E);
    write_byte(8'h11);
    tx_q.push_back(8'h5A);
    exp_req.push_back(1);
    exp_bus.push_back(0); exp_bus.push_back(8'h5A);
    start_cond();
    write_byte(8'h8F);
    chk("rs_rd_nwr", int'(rd_nwr), 1);
    read_byte(1'b1);
    stop_cond();
    wait_q();

    // General call
`ifdef I2C_TARGET_GCALL_EN
    exp_bus.push_back(0); exp_bus.push_back(0);
    exp_rx.push_back(8'h06);
`else
    exp_bus.push_back(1); exp_bus.push_back(1);
`endif
    start_cond();
    write_byte(8'h00);
    write_byte(8'h06);
    stop_cond();
    wait_q();

    // Reset while target drives bit 5 of a read byte (tx 00 -> SDA pulled)
    tx_q.push_back(8'h00);
    exp_req.push_back(1);
    exp_bus.push_back(0);
    start_cond();
    write_byte(8'h8F);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    chk("bit5_driven", int'(sda_oe), 1);
    rst = 1'b1;
    #1;
    chk("midreset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_scl_low = 1'b0; m_sda_low = 1'b0;
    wait_q(); wait_q();
    exp_bus.push_back(0); exp_bus.push_back(0);
    exp_rx.push_back(8'h5A);
    start_cond();
    write_byte(8'h8E);
    write_byte(8'h5A);
    stop_cond();
    wait_q();

    repeat (20) @(negedge clk);
    chk("rx_pending", exp_rx.size(), 0);
    chk("req_pending", exp_req.size(), 0);
    chk("bus_pending", exp_bus.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
